// File: rtl/encoder32_pkg.sv
// Shared constants and types for the 32-entry pending-request encoder.
package encoder32_pkg;
  localparam int N     = 32;
  localparam int IDX_W = 5;

  typedef logic [N-1:0]     vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic vec_t onehot(input idx_t idx);
    onehot = vec_t'(1) << idx;
  endfunction
endpackage

// File: rtl/pending_encoder32_prio_find32.sv
// Combinational lowest-set-bit finder over a 32-bit vector.
module prio_find32
  import encoder32_pkg::*;
(
  input  vec_t vec,
  output idx_t idx,
  output logic found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = idx_t'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pending_encoder32.sv
// Captures request bits into a pending set and grants one index per cycle.
// Optional round-robin search start enabled by macro PENDING_ENCODER32_RR_EN.
module pending_encoder32
  import encoder32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] req_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] pending,
  output logic        any_pending
);
  // Handshake: out_index transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_valid and out_index hold unchanged.

  vec_t pending_q;
  vec_t pending_next;
  vec_t load_mask;
  logic valid_q;
  idx_t index_q;
  logic any_q;
  idx_t sel_idx;
  logic sel_found;
  logic stage_free;
  logic load;

`ifdef PENDING_ENCODER32_RR_EN
  idx_t ptr_q;
  vec_t masked_vec;
  idx_t masked_idx;
  logic masked_found;
  idx_t full_idx;

  assign masked_vec = pending_q & (vec_t'({N{1'b1}}) << ptr_q);

  prio_find32 u_find_masked (
    .vec   (masked_vec),
    .idx   (masked_idx),
    .found (masked_found)
  );

  prio_find32 u_find_full (
    .vec   (pending_q),
    .idx   (full_idx),
    .found (sel_found)
  );

  assign sel_idx = masked_found ? masked_idx : full_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (load) begin
      // 5-bit add wraps 31 back to 0.
      ptr_q <= sel_idx + idx_t'(1);
    end
  end
`else
  prio_find32 u_find (
    .vec   (pending_q),
    .idx   (sel_idx),
    .found (sel_found)
  );
`endif

  assign stage_free = !valid_q || out_ready;
  assign load       = stage_free && sel_found;
  assign load_mask  = load ? onehot(sel_idx) : '0;

  // New requests are OR'd in after the clear, so a same-cycle set wins.
  assign pending_next = (pending_q & ~load_mask) | (en ? req_in : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      any_q     <= 1'b0;
    end else begin
      pending_q <= pending_next;
      any_q     <= |pending_next;
      if (stage_free) begin
        valid_q <= sel_found;
      end
      if (load) begin
        index_q <= sel_idx;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_index   = index_q;
  assign pending     = pending_q;
  assign any_pending = any_q;
endmodule

// File: tb/tb_pending_encoder32.sv
// Self-checking bench for pending_encoder32: directed table, corner sequences, random vs model.
module tb_pending_encoder32;
  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] req_in;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] pending;
  logic        any_pending;

  int vectors;
  int miscompares;

`ifdef PENDING_ENCODER32_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  pending_encoder32 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_in      (req_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .pending     (pending),
    .any_pending (any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the block should hold after each edge.
  logic [31:0] m_pend;
  logic        m_valid;
  logic [4:0]  m_idx;
  int          m_ptr;

  // Lowest set index at or after ptr, wrapping; -1 when nothing is set.
  function automatic int find_grant(input logic [31:0] vec, input int ptr);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (ptr + k) % 32;
      if (vec[j]) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [31:0] rq, input logic rdy);
    logic [31:0] np;
    int g;
    if (r) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_ptr = 0;
    end else begin
      np = m_pend;
      if (!m_valid || rdy) begin
        g = find_grant(m_pend, RR ? m_ptr : 0);
        if (g >= 0) begin
          np[g]   = 1'b0;
          m_valid = 1'b1;
          m_idx   = 5'(g);
          m_ptr   = (g + 1) % 32;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = np | (e ? rq : 32'h0);
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare against the model.
  task automatic tick(input logic r, input logic e, input logic [31:0] rq, input logic rdy);
    rst = r; en = e; req_in = rq; out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, e, rq, rdy);
    check("model_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) check("model_index", 32'(out_index), 32'(m_idx));
    check("model_pending", pending, m_pend);
    check("model_any", 32'(any_pending), 32'(m_pend != 0));
  endtask

  task automatic expect_grant(input string name, input logic [4:0] idx);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_index"}, 32'(out_index), 32'(idx));
  endtask

  typedef struct {
    logic        r;
    logic        e;
    logic [31:0] rq;
    logic        rdy;
    logic        exp_valid;
    logic [4:0]  exp_index;
    logic [31:0] exp_pend;
  } vec_rec_t;

  vec_rec_t tbl[12];

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; en = 1'b0; req_in = '0; out_ready = 1'b0;
    m_pend = '0; m_valid = 1'b0; m_idx = '0; m_ptr = 0;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 5'd0,  32'h0000_0001};
    tbl[2]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd0,  32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
    tbl[4]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
    tbl[5]  = '{1'b0, 1'b1, 32'h8000_0011, 1'b1, 1'b0, 5'd0,  32'h8000_0011};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd0,  32'h8000_0010};
    tbl[7]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd4,  32'h8000_0000};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd31, 32'h0000_0000};
    tbl[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd31, 32'h0000_0000};
    tbl[10] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd31, 32'h0000_0000};
    tbl[11] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd31, 32'h0000_0000};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].rq, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_index", i), 32'(out_index), 32'(tbl[i].exp_index));
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].exp_pend);
      check($sformatf("tbl%0d_any", i), 32'(any_pending), 32'(tbl[i].exp_pend != 0));
    end

    // Stall with index 3 held; re-request bit 3 during the stall.
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_0008, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    expect_grant("stall_load", 5'd3);
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, c == 2, 32'h0000_0008, 1'b0);
      expect_grant($sformatf("stall_hold%0d", c), 5'd3);
    end
    check("stall_repend", pending, 32'h0000_0008);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_grant("stall_regrant", 5'd3);
    check("stall_drained", pending, 32'h0);

`ifdef PENDING_ENCODER32_RR_EN
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h8000_0000, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_grant("rr_31", 5'd31);
    tick(1'b0, 1'b1, 32'h0000_0005, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_grant("rr_wrap0", 5'd0);
    tick(1'b0, 1'b1, 32'h0000_0020, 1'b1);
    expect_grant("rr_2", 5'd2);
    tick(1'b0, 1'b1, 32'h0000_0084, 1'b1);
    expect_grant("rr_5", 5'd5);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_grant("rr_7", 5'd7);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_grant("rr_2b", 5'd2);
`endif

    // Reset while a grant is held and more requests are pending.
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_0001, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_00F0, 1'b0);
    expect_grant("rstmid_pre", 5'd0);
    check("rstmid_pre_pending", pending, 32'h0000_00F0);
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_pending", pending, 32'h0);
    check("rstmid_any", 32'(any_pending), 32'd0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("rstmid_no_emit", 32'(out_valid), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rq;
      case ($urandom_range(0, 3))
        0: rq = $urandom();
        1: rq = 32'h1 << $urandom_range(0, 31);
        2: rq = 32'h0;
        default: rq = $urandom() & $urandom() & $urandom();
      endcase
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rq, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
